// File: rtl/sb_dbuf_if.sv
// Track-side bundle of the switchbox: one WIDTH-bit input and one output bus per side.
// The fabric (master) drives the *_in buses; the switchbox (slave) drives the *_out buses.
interface sb_track_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] north_in;
  logic [WIDTH-1:0] east_in;
  logic [WIDTH-1:0] south_in;
  logic [WIDTH-1:0] west_in;
  logic [WIDTH-1:0] north_out;
  logic [WIDTH-1:0] east_out;
  logic [WIDTH-1:0] south_out;
  logic [WIDTH-1:0] west_out;

  modport master (
    output north_in, east_in, south_in, west_in,
    input  north_out, east_out, south_out, west_out
  );

  modport slave (
    input  north_in, east_in, south_in, west_in,
    output north_out, east_out, south_out, west_out
  );
endinterface

// File: rtl/sb_dbuf.sv
// Double-buffered switchbox: serial shadow chain plus an atomically committed active
// routing word with a 2-bit source select per track and output side.
module sb_dbuf #(
  parameter int WIDTH   = 8,
  parameter int OUT_REG = 0
) (
  input  logic           clk,
  input  logic           nrst,
  sb_track_if.slave      trk,
  input  logic           en,
  input  logic           config_en,
  input  logic           config_data_in,
  input  logic           config_commit,
  output logic           config_data_out,
  output logic           cfg_ready,
  output logic           cfg_err
);

  localparam int CFG_BITS = WIDTH * 8;
  localparam int CW       = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                do_commit, do_shift;

  // Commit outranks shift; a commit only takes effect once the shift count is complete.
  assign do_commit = en & config_commit;
  assign do_shift  = en & config_en & ~config_commit;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (do_commit) begin
      if (cnt_q == CNT_FULL) begin
        active_d = shadow_q;
        cnt_d    = '0;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end else if (do_shift) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], config_data_in};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign config_data_out = shadow_q[CFG_BITS-1];
  assign cfg_ready       = (cnt_q == CNT_FULL);
  assign cfg_err         = err_q;

  logic [WIDTH-1:0] side_in [4];
  logic [WIDTH-1:0] route_d [4];
  logic [WIDTH-1:0] out_v   [4];

  assign side_in[0] = trk.north_in;
  assign side_in[1] = trk.east_in;
  assign side_in[2] = trk.south_in;
  assign side_in[3] = trk.west_in;

  // Select code k on output side d picks input side (d+k) mod 4; the 2-bit add wraps for us.
  always_comb begin
    logic [1:0] sel;
    logic [1:0] src;
    sel = 2'b00;
    src = 2'b00;
    for (int d = 0; d < 4; d++) begin
      route_d[d] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int d = 0; d < 4; d++) begin
        sel           = active_q[i*8 + d*2 +: 2];
        src           = 2'(d) + sel;
        route_d[d][i] = (sel != 2'b00) & side_in[src][i];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] out_q [4];

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int d = 0; d < 4; d++) begin
            out_q[d] <= '0;
          end
        end else begin
          for (int d = 0; d < 4; d++) begin
            out_q[d] <= route_d[d];
          end
        end
      end

      for (genvar d = 0; d < 4; d++) begin : g_side
        assign out_v[d] = out_q[d];
      end
    end else begin : g_out_comb
      for (genvar d = 0; d < 4; d++) begin : g_side
        assign out_v[d] = route_d[d];
      end
    end
  endgenerate

  assign trk.north_out = out_v[0];
  assign trk.east_out  = out_v[1];
  assign trk.south_out = out_v[2];
  assign trk.west_out  = out_v[3];

endmodule

// File: tb/tb_sb_dbuf.sv
// Bench for sb_dbuf: a combinational and a registered instance share all stimulus and
// are checked every cycle against a queue-based model of the shadow chain and routing rules.
module tb_sb_dbuf;

  localparam int W  = 2;
  localparam int CB = W * 8;

  logic clk, nrst, en, cen, din, commit;
  logic [W-1:0] n_in, e_in, s_in, w_in;
  logic dout0, rdy0, err0, dout1, rdy1, err1;

  sb_track_if #(.WIDTH(W)) if0 ();
  sb_track_if #(.WIDTH(W)) if1 ();

  assign if0.north_in = n_in;
  assign if0.east_in  = e_in;
  assign if0.south_in = s_in;
  assign if0.west_in  = w_in;
  assign if1.north_in = n_in;
  assign if1.east_in  = e_in;
  assign if1.south_in = s_in;
  assign if1.west_in  = w_in;

  sb_dbuf #(.WIDTH(W), .OUT_REG(0)) dut0 (
    .clk(clk), .nrst(nrst), .trk(if0), .en(en), .config_en(cen),
    .config_data_in(din), .config_commit(commit),
    .config_data_out(dout0), .cfg_ready(rdy0), .cfg_err(err0)
  );

  sb_dbuf #(.WIDTH(W), .OUT_REG(1)) dut1 (
    .clk(clk), .nrst(nrst), .trk(if1), .en(en), .config_en(cen),
    .config_data_in(din), .config_commit(commit),
    .config_data_out(dout1), .cfg_ready(rdy1), .cfg_err(err1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: shadow as a bit queue (index 0 = MSB = oldest bit)
  bit           sh_q[$];
  bit [CB-1:0]  m_act;
  int           m_cnt;
  bit           m_err;
  logic [W-1:0] exp1 [4];

  function automatic logic [W-1:0] route_side(input int d, input bit [CB-1:0] act,
      input logic [W-1:0] a0, input logic [W-1:0] a1,
      input logic [W-1:0] a2, input logic [W-1:0] a3);
    logic [W-1:0] ins [4];
    logic [W-1:0] r;
    int sel;
    ins = '{a0, a1, a2, a3};
    r = '0;
    for (int i = 0; i < W; i++) begin
      sel = int'(act[i*8 + d*2 +: 2]);
      if (sel != 0) r[i] = ins[(d + sel) % 4][i];
    end
    return r;
  endfunction

  task automatic model_reset();
    sh_q.delete();
    for (int k = 0; k < CB; k++) sh_q.push_back(1'b0);
    m_act = '0;
    m_cnt = 0;
    m_err = 1'b0;
    for (int d = 0; d < 4; d++) exp1[d] = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock edge; the model advances from the inputs held across the edge
  task automatic cycle();
    logic [W-1:0] e1 [4];
    for (int d = 0; d < 4; d++)
      e1[d] = nrst ? route_side(d, m_act, n_in, e_in, s_in, w_in) : '0;
    @(posedge clk);
    if (nrst) begin
      if (en && commit) begin
        if (m_cnt == CB) begin
          for (int k = 0; k < CB; k++) m_act[k] = sh_q[CB-1-k];
          m_cnt = 0;
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end else if (en && cen) begin
        sh_q.push_back(din);
        void'(sh_q.pop_front());
        if (m_cnt < CB) m_cnt++;
      end
      for (int d = 0; d < 4; d++) exp1[d] = e1[d];
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] o0 [4];
    logic [W-1:0] o1 [4];
    #1;
    o0 = '{if0.north_out, if0.east_out, if0.south_out, if0.west_out};
    o1 = '{if1.north_out, if1.east_out, if1.south_out, if1.west_out};
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_comb_side%0d", tag, d), 32'(o0[d]),
          32'(route_side(d, m_act, n_in, e_in, s_in, w_in)));
      chk($sformatf("%s_reg_side%0d", tag, d), 32'(o1[d]), 32'(exp1[d]));
    end
    chk({tag, "_ready0"}, 32'(rdy0), 32'(m_cnt == CB));
    chk({tag, "_ready1"}, 32'(rdy1), 32'(m_cnt == CB));
    chk({tag, "_err0"},   32'(err0), 32'(m_err));
    chk({tag, "_err1"},   32'(err1), 32'(m_err));
    chk({tag, "_dout0"},  32'(dout0), 32'(sh_q[0]));
    chk({tag, "_dout1"},  32'(dout1), 32'(sh_q[0]));
  endtask

  // shift bits [first, first+count) of cfg, MSB first; optionally toggle north_in each cycle
  task automatic shift_bits(input logic [CB-1:0] cfg, input int first, input int count,
                            input bit toggle_n);
    for (int j = first; j < first + count; j++) begin
      cen = 1'b1;
      din = cfg[CB-1-j];
      if (toggle_n) n_in = ~n_in;
      check_all("shift");
      if (toggle_n) chk("live_south", 32'(if0.south_out), 32'(n_in));
      cycle();
    end
    cen = 1'b0;
    din = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    check_all("commit_pre");
    cycle();
    commit = 1'b0;
    check_all("commit_post");
  endtask

  logic [CB-1:0] cfg_multi, cfg_ns, cfg_ew, cfg_rnd;

  initial begin
    nrst = 1'b0; en = 1'b1; cen = 1'b0; din = 1'b0; commit = 1'b0;
    n_in = '1; e_in = '1; s_in = '1; w_in = '1;
    model_reset();

    // reset with all-ones inputs
    #2;
    check_all("reset");
    chk("reset_north_zero", 32'(if0.north_out), 32'h0);
    cycle();
    cycle();
    nrst = 1'b1;
    check_all("after_reset");

    // track0: west from N (01), south from E (11)
    cfg_multi = 16'h0070;
    shift_bits(cfg_multi, 0, CB, 1'b0);
    do_commit();
    n_in = 2'b01; e_in = 2'b01; s_in = 2'b00; w_in = 2'b00;
    check_all("multi");
    chk("multi_west",  32'(if0.west_out),  32'h1);
    chk("multi_south", 32'(if0.south_out), 32'h1);
    chk("multi_north", 32'(if0.north_out), 32'h0);
    chk("multi_east",  32'(if0.east_out),  32'h0);
    cycle();

    // incomplete commit, then completion: N->S on both tracks
    cfg_ns = 16'h2020;
    shift_bits(cfg_ns, 0, 10, 1'b0);
    do_commit();
    chk("partial_err", 32'(err0), 32'h1);
    shift_bits(cfg_ns, 10, 6, 1'b0);
    do_commit();
    chk("complete_err", 32'(err0), 32'h0);

    // live shifting of E->W while N->S is active
    cfg_ew = 16'h8080;
    shift_bits(cfg_ew, 0, CB, 1'b1);
    do_commit();
    e_in = 2'b10;
    check_all("ew_toggle");
    chk("ew_comb", 32'(if0.west_out), 32'h2);
    cycle();
    check_all("ew_next");
    chk("ew_reg", 32'(if1.west_out), 32'h2);

    // commit and shift requested together while ready
    cfg_rnd = 16'($urandom);
    shift_bits(cfg_rnd, 0, CB, 1'b0);
    cen = 1'b1; commit = 1'b1; din = 1'b1;
    cycle();
    cen = 1'b0; commit = 1'b0; din = 1'b0;
    check_all("collide");
    chk("collide_ready", 32'(rdy0), 32'h0);
    chk("collide_dout",  32'(dout0), 32'(cfg_rnd[CB-1]));

    // disabled: shifts and a would-fail commit are ignored
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cen = 1'b1;
      din = 1'($urandom_range(0, 1));
      commit = (k == 4);
      e_in = 2'($urandom);
      check_all("disabled");
      cycle();
    end
    cen = 1'b0; commit = 1'b0; en = 1'b1;
    check_all("disabled_end");
    chk("disabled_err", 32'(err0), 32'h0);

    // registered E->W stream, then asynchronous reset mid-shift
    shift_bits(cfg_ew, 0, CB, 1'b0);
    do_commit();
    for (int k = 0; k < 6; k++) begin
      e_in = ~e_in;
      n_in = 2'($urandom);
      cen = 1'b1;
      din = 1'($urandom_range(0, 1));
      check_all("ew_stream");
      cycle();
    end
    e_in = 2'b11;
    nrst = 1'b0;
    model_reset();
    check_all("async_reset");
    chk("async_reset_west1", 32'(if1.west_out), 32'h0);
    cycle();
    cen = 1'b0;
    #2;
    nrst = 1'b1;
    check_all("reset_release");

    // randomized phase
    for (int k = 0; k < 400; k++) begin
      en     = ($urandom_range(0, 9) != 0);
      cen    = ($urandom_range(0, 3) != 0);
      commit = ($urandom_range(0, 14) == 0);
      din    = 1'($urandom_range(0, 1));
      n_in = 2'($urandom); e_in = 2'($urandom);
      s_in = 2'($urandom); w_in = 2'($urandom);
      check_all("random");
      cycle();
    end
    en = 1'b1; cen = 1'b0; commit = 1'b0;
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
